uart_rx_os: RTL and testbench
=============================

UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 SHALL provide parameter CLK_FREQ, default 1_000_000, system clock frequency in Hz.
REQ-002 SHALL provide parameter BAUD, default 9600, line rate in bit/s.
REQ-003 SHALL provide parameter DATA_BITS, default 8, legal 5..9, payload bits per frame.
REQ-004 SHALL provide parameter OVERSAMPLE, default 16, legal even 8..16, sample ticks per bit.
REQ-005 SHALL have one clock and a synchronous, active-high reset; ports: clk input 1 system clock; rst input 1 synchronous active-high reset.
REQ-006 SHALL have port rx  input  1  serial line, idle high, asynchronous to clk.
REQ-007 SHALL have port dout_rx  output  DATA_BITS  received payload, LSB first on line.
REQ-008 SHALL have port valid_rx  output  1  dout_rx holds an unconsumed frame.
REQ-009 SHALL have port ready_rx  input  1  consumer accepts dout_rx.
REQ-010 SHALL have port frame_err  output  1  one-clk pulse, stop bit sampled low.
REQ-011 SHALL have port overrun_err  output  1  one-clk pulse, frame dropped because valid_rx was still high.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer before any use; reset value of both flops 1.
REQ-013 SHALL generate a one-clk sample tick every DIV = max(1, round(CLK_FREQ/(BAUD*OVERSAMPLE))) clks, free-running.
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; PARITY reachable only per REQ-024.
REQ-015 IDLE -> START on synchronized rx low at a tick; sample counter cleared.
REQ-016 START SHALL re-sample rx at tick OVERSAMPLE/2; low -> DATA with counters cleared, high -> IDLE (false start, no output activity).
REQ-017 DATA SHALL sample rx every OVERSAMPLE ticks (bit centre), shifting LSB first; after DATA_BITS samples -> PARITY or STOP.
REQ-018 STOP SHALL sample rx at bit centre; high -> frame accepted; low -> frame_err pulse, frame discarded, dout_rx unchanged; both -> IDLE.
REQ-019 Accepted frame SHALL load dout_rx and raise valid_rx on the clk after the stop-bit sample.
REQ-020 valid_rx SHALL remain high and dout_rx stable until a clk with valid_rx and ready_rx both high; valid_rx falls the following clk.
REQ-021 Frame accepted while valid_rx high and ready_rx low SHALL pulse overrun_err and drop the new frame; if ready_rx high in that same clk, new frame loads, valid_rx stays high, no overrun.
REQ-022 Receiver SHALL return to IDLE within the stop bit so back-to-back frames with one stop bit are received without loss.

Reset
REQ-023 On rst high at a clk edge: state IDLE, all counters 0, dout_rx 0, valid_rx 0, frame_err 0, overrun_err 0, parity_err 0; reset mid-frame SHALL abandon the frame with no output pulse.

Configuration
REQ-024 Macro UART_RX_PARITY_EN: defined -> parameter PARITY_ODD (default 0, even) and output parity_err (1-clk pulse); PARITY state samples one bit after data, mismatch -> parity_err pulse, frame discarded; undefined -> no PARITY state, no parity_err port, frame = start + DATA_BITS + stop.

Structure
REQ-025 Package uart_pkg SHALL hold the FSM state enum, the DIV computation function and legal-range constants for DATA_BITS/OVERSAMPLE.
REQ-026 Tick generation SHALL be sub-module uart_baud_tick (parameter DIV, ports clk, rst, tick), reusable by the transmitter.

Verification (CLK_FREQ=1_600_000, BAUD=10_000, OVERSAMPLE=16 -> DIV=10, 160 clk/bit)
REQ-027 Frame 0xA5, ready_rx high -> valid_rx 1 clk, dout_rx=0xA5, no error pulses.
REQ-028 rx low for 30 clk then high -> no valid_rx, no error pulse, next frame 0x3C received correctly.
REQ-029 Frame 0x3C with stop bit low -> frame_err single pulse, valid_rx stays 0, dout_rx unchanged.
REQ-030 Frames 0x11 then 0x22 back-to-back, ready_rx low -> dout_rx=0x11 held, overrun_err pulse; raise ready_rx -> valid_rx drops next clk.
REQ-031 rst high mid-DATA of 0xFF, then frame 0x5A -> all outputs 0 after reset, dout_rx=0x5A afterwards.
REQ-032 UART_RX_PARITY_EN, even: 0x07 with parity 1 -> accepted; parity 0 -> parity_err pulse, no valid_rx.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding, legal parameter
// ranges, the sample-tick divider calculation and the parity helper.
package uart_pkg;

    // Receiver frame-walk states; ST_PARITY is only entered when parity is built in.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int DATA_BITS_MIN  = 32'sd5;
    localparam int DATA_BITS_MAX  = 32'sd9;
    localparam int OVERSAMPLE_MIN = 32'sd8;
    localparam int OVERSAMPLE_MAX = 32'sd16;

    // Clocks per sample tick, rounded to nearest and never below one.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        int denom;
        int quot;
        denom = baud * oversample;
        quot  = (clk_freq + (denom / 32'sd2)) / denom;
        return (quot < 32'sd1) ? 32'sd1 : quot;
    endfunction

    // Expected parity bit for a zero-extended payload (odd selects odd parity).
    function automatic logic parity_bit(input logic [DATA_BITS_MAX-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running sample-tick generator: one-clk tick every DIV clocks.
// Shared between the UART receiver and transmitter.
module uart_baud_tick #(
    parameter int DIV = 32'sd10
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int            CW   = (DIV > 32'sd1) ? $clog2(DIV) : 32'sd1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 32'sd1);

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Divider counter wraps at DIV-1 and emits a registered one-clk tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (cnt_r == LAST) begin
            cnt_r  <= '0;
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + 1'b1;
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with valid/ready output handshake.
// Optional parity checking is built in when UART_RX_PARITY_EN is defined,
// which adds parameter PARITY_ODD and output parity_err.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 32'sd1_000_000,
    parameter int BAUD       = 32'sd9600,
    parameter int DATA_BITS  = 32'sd8,
    parameter int OVERSAMPLE = 32'sd16
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 ready_rx,
    output logic [DATA_BITS-1:0] dout_rx,
    output logic                 valid_rx,
    output logic                 frame_err,
    output logic                 overrun_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int             DIV       = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int             SCW       = $clog2(OVERSAMPLE);
    localparam int             BCW       = $clog2(DATA_BITS_MAX);
    localparam logic [SCW-1:0] HALF_LAST = SCW'((OVERSAMPLE / 32'sd2) - 32'sd1);
    localparam logic [SCW-1:0] FULL_LAST = SCW'(OVERSAMPLE - 32'sd1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_BITS - 32'sd1);

    logic                 rx_meta_r;
    logic                 rx_sync_r;
    logic                 tick_s;

    uart_state_e          state_r;
    uart_state_e          state_nx_s;
    logic [SCW-1:0]       samp_cnt_r;
    logic [SCW-1:0]       samp_cnt_nx_s;
    logic [BCW-1:0]       bit_cnt_r;
    logic [BCW-1:0]       bit_cnt_nx_s;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] shift_nx_s;
    logic                 par_bad_r;
    logic                 par_bad_nx_s;

    logic                 accept_s;
    logic                 frame_fail_s;
    logic                 parity_fail_s;

    logic [DATA_BITS-1:0] dout_r;
    logic                 valid_r;
    logic                 frame_err_r;
    logic                 overrun_err_r;
    logic                 parity_err_r;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_s)
    );

    // Two-flop synchronizer for the asynchronous line; idles at mark (1).
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Frame-walk state and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            samp_cnt_r <= '0;
            bit_cnt_r  <= '0;
            shift_r    <= '0;
            par_bad_r  <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            samp_cnt_r <= samp_cnt_nx_s;
            bit_cnt_r  <= bit_cnt_nx_s;
            shift_r    <= shift_nx_s;
            par_bad_r  <= par_bad_nx_s;
        end
    end

    // Next-state logic: every decision is taken on a sample tick; the start
    // bit is checked at half a bit, all later bits at their centres.
    always_comb begin
        state_nx_s    = state_r;
        samp_cnt_nx_s = samp_cnt_r;
        bit_cnt_nx_s  = bit_cnt_r;
        shift_nx_s    = shift_r;
        par_bad_nx_s  = par_bad_r;
        accept_s      = 1'b0;
        frame_fail_s  = 1'b0;
        parity_fail_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (tick_s && !rx_sync_r) begin
                    state_nx_s    = ST_START;
                    samp_cnt_nx_s = '0;
                    par_bad_nx_s  = 1'b0;
                end else begin
                    state_nx_s    = ST_IDLE;
                end
            end

            ST_START: begin
                if (tick_s) begin
                    if (samp_cnt_r == HALF_LAST) begin
                        samp_cnt_nx_s = '0;
                        bit_cnt_nx_s  = '0;
                        // A line already back at mark was a glitch: drop silently.
                        state_nx_s    = rx_sync_r ? ST_IDLE : ST_DATA;
                    end else begin
                        samp_cnt_nx_s = samp_cnt_r + 1'b1;
                    end
                end else begin
                    state_nx_s = ST_START;
                end
            end

            ST_DATA: begin
                if (tick_s) begin
                    if (samp_cnt_r == FULL_LAST) begin
                        samp_cnt_nx_s = '0;
                        shift_nx_s    = {rx_sync_r, shift_r[DATA_BITS-1:1]};
                        if (bit_cnt_r == BIT_LAST) begin
                            bit_cnt_nx_s = '0;
`ifdef UART_RX_PARITY_EN
                            state_nx_s   = ST_PARITY;
`else
                            state_nx_s   = ST_STOP;
`endif
                        end else begin
                            bit_cnt_nx_s = bit_cnt_r + 1'b1;
                        end
                    end else begin
                        samp_cnt_nx_s = samp_cnt_r + 1'b1;
                    end
                end else begin
                    state_nx_s = ST_DATA;
                end
            end

            ST_PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (tick_s) begin
                    if (samp_cnt_r == FULL_LAST) begin
                        samp_cnt_nx_s = '0;
                        state_nx_s    = ST_STOP;
                        // A bad frame still walks through its stop bit so the
                        // next start edge is found cleanly.
                        if (rx_sync_r != parity_bit(DATA_BITS_MAX'(shift_r), PARITY_ODD)) begin
                            par_bad_nx_s  = 1'b1;
                            parity_fail_s = 1'b1;
                        end else begin
                            par_bad_nx_s  = 1'b0;
                        end
                    end else begin
                        samp_cnt_nx_s = samp_cnt_r + 1'b1;
                    end
                end else begin
                    state_nx_s = ST_PARITY;
                end
`else
                state_nx_s = ST_IDLE;
`endif
            end

            ST_STOP: begin
                if (tick_s) begin
                    if (samp_cnt_r == FULL_LAST) begin
                        // Leave at stop-bit centre so a back-to-back start edge is caught.
                        samp_cnt_nx_s = '0;
                        state_nx_s    = ST_IDLE;
                        if (!rx_sync_r) begin
                            frame_fail_s = 1'b1;
                        end else if (!par_bad_r) begin
                            accept_s     = 1'b1;
                        end else begin
                            accept_s     = 1'b0;
                        end
                    end else begin
                        samp_cnt_nx_s = samp_cnt_r + 1'b1;
                    end
                end else begin
                    state_nx_s = ST_STOP;
                end
            end

            default: begin
                state_nx_s    = ST_IDLE;
                samp_cnt_nx_s = '0;
                bit_cnt_nx_s  = '0;
            end
        endcase
    end

    // Output holding register, handshake and one-clk error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_r        <= '0;
            valid_r       <= 1'b0;
            frame_err_r   <= 1'b0;
            overrun_err_r <= 1'b0;
            parity_err_r  <= 1'b0;
        end else begin
            frame_err_r   <= frame_fail_s;
            parity_err_r  <= parity_fail_s;
            overrun_err_r <= 1'b0;
            if (accept_s) begin
                // Consumer taking the old word this clk frees the slot for the new one.
                if (!valid_r || ready_rx) begin
                    dout_r  <= shift_r;
                    valid_r <= 1'b1;
                end else begin
                    overrun_err_r <= 1'b1;
                end
            end else if (valid_r && ready_rx) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    assign dout_rx     = dout_r;
    assign valid_rx    = valid_r;
    assign frame_err   = frame_err_r;
    assign overrun_err = overrun_err_r;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = parity_err_r;
`else
    // Parity never fails without a parity bit; register kept for uniform reset.
    logic unused_parity_s;
    assign unused_parity_s = parity_err_r;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os at 1.6 MHz / 10 kbaud / x16 (160 clk per bit).
// Parity steps are included when UART_RX_PARITY_EN is defined.
module tb_uart_rx_os;

    localparam int BIT = 160;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       ready_rx;
    logic [7:0] dout_rx;
    logic       valid_rx;
    logic       frame_err;
    logic       overrun_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int errors = 0;
    int checks = 0;

    int valid_cyc = 0;
    int ferr_cyc  = 0;
    int ovr_cyc   = 0;
    int perr_cyc  = 0;

    int v0, f0, o0, p0;

    uart_rx_os #(
        .CLK_FREQ   (1_600_000),
        .BAUD       (10_000),
        .DATA_BITS  (8),
        .OVERSAMPLE (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .ready_rx    (ready_rx),
        .dout_rx     (dout_rx),
        .valid_rx    (valid_rx),
        .frame_err   (frame_err),
        .overrun_err (overrun_err)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err  (parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count high cycles of each output strobe.
    always @(negedge clk) begin
        if (valid_rx)    valid_cyc <= valid_cyc + 1;
        if (frame_err)   ferr_cyc  <= ferr_cyc + 1;
        if (overrun_err) ovr_cyc   <= ovr_cyc + 1;
`ifdef UART_RX_PARITY_EN
        if (parity_err)  perr_cyc  <= perr_cyc + 1;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        hold(1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(d[i], BIT);
        hold(stop, BIT);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] d, input logic par);
        hold(1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(d[i], BIT);
        hold(par, BIT);
        hold(1'b1, BIT);
    endtask
`endif

    task automatic snap();
        v0 = valid_cyc;
        f0 = ferr_cyc;
        o0 = ovr_cyc;
        p0 = perr_cyc;
    endtask

    initial begin
        rst      = 1'b1;
        rx       = 1'b1;
        ready_rx = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_dout",    32'(dout_rx),     32'h0);
        chk("reset_valid",   32'(valid_rx),    32'h0);
        chk("reset_ferr",    32'(frame_err),   32'h0);
        chk("reset_overrun", 32'(overrun_err), 32'h0);
        rst = 1'b0;
        hold(1'b1, 50);

        // Clean frame with consumer ready: one-clk valid.
        snap();
        send_frame(8'hA5, 1'b1);
        hold(1'b1, 20);
        chk("a5_valid_cycles", 32'(valid_cyc - v0), 32'd1);
        chk("a5_dout",         32'(dout_rx),         32'hA5);
        chk("a5_no_ferr",      32'(ferr_cyc - f0),   32'd0);
        chk("a5_no_overrun",   32'(ovr_cyc - o0),    32'd0);
        chk("a5_valid_low",    32'(valid_rx),        32'h0);

        // Stop bit low: framing error, nothing delivered, old data kept.
        snap();
        send_frame(8'h3C, 1'b0);
        hold(1'b1, 200);
        chk("ferr_pulse",   32'(ferr_cyc - f0),   32'd1);
        chk("ferr_novalid", 32'(valid_cyc - v0),  32'd0);
        chk("ferr_dout",    32'(dout_rx),         32'hA5);

        // Short low glitch: false start, no activity; next frame received.
        snap();
        hold(1'b0, 30);
        hold(1'b1, 200);
        chk("glitch_novalid", 32'(valid_cyc - v0), 32'd0);
        chk("glitch_noferr",  32'(ferr_cyc - f0),  32'd0);
        chk("glitch_noovr",   32'(ovr_cyc - o0),   32'd0);
        send_frame(8'h3C, 1'b1);
        hold(1'b1, 20);
        chk("3c_valid_cycles", 32'(valid_cyc - v0), 32'd1);
        chk("3c_dout",         32'(dout_rx),        32'h3C);

        // Back-to-back frames with consumer stalled: second one overruns.
        ready_rx = 1'b0;
        snap();
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        hold(1'b1, 20);
        chk("ovr_valid_held", 32'(valid_rx),       32'h1);
        chk("ovr_dout_held",  32'(dout_rx),        32'h11);
        chk("ovr_pulse",      32'(ovr_cyc - o0),   32'd1);
        chk("ovr_noferr",     32'(ferr_cyc - f0),  32'd0);
        ready_rx = 1'b1;
        @(negedge clk);
        chk("ovr_valid_drop", 32'(valid_rx),       32'h0);

        // Reset in the middle of the data bits of 0xFF.
        hold(1'b1, 50);
        hold(1'b0, BIT);
        hold(1'b1, 3 * BIT);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_dout",  32'(dout_rx),     32'h0);
        chk("midrst_valid", 32'(valid_rx),    32'h0);
        chk("midrst_ferr",  32'(frame_err),   32'h0);
        chk("midrst_ovr",   32'(overrun_err), 32'h0);
        rst = 1'b0;
        snap();
        hold(1'b1, 6 * BIT + 100);
        chk("postrst_novalid", 32'(valid_cyc - v0), 32'd0);
        chk("postrst_noferr",  32'(ferr_cyc - f0),  32'd0);
        send_frame(8'h5A, 1'b1);
        hold(1'b1, 20);
        chk("5a_valid_cycles", 32'(valid_cyc - v0), 32'd1);
        chk("5a_dout",         32'(dout_rx),        32'h5A);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so the parity bit must be 1.
        snap();
        send_frame_par(8'h07, 1'b1);
        hold(1'b1, 20);
        chk("par_ok_valid", 32'(valid_cyc - v0), 32'd1);
        chk("par_ok_dout",  32'(dout_rx),        32'h07);
        chk("par_ok_nerr",  32'(perr_cyc - p0),  32'd0);
        snap();
        send_frame_par(8'h07, 1'b0);
        hold(1'b1, 20);
        chk("par_bad_pulse",   32'(perr_cyc - p0),  32'd1);
        chk("par_bad_novalid", 32'(valid_cyc - v0), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
